rr_index_arbiter: RTL and testbench

//   Round-robin arbiter over 16 request lines. Produces a registered 4-bit winner

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 38 +++
 rtl/rr_index_arbiter.sv | 97 +++++++++
 tb/tb_rr_index_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and fixed sizes for the round-robin index arbiter.
// The arbiter drives a 4-to-16 decoder, so the requester count and index width are fixed.
package arb_pkg;

   localparam int N_REQ = 16;
   localparam int IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick.
// Finds the first set request bit when scanning from ptr upward, wrapping modulo 16.
module rr_priority_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   assign any = |req;

   // Rotate requests right by ptr so that bit 0 of rot is requester ptr.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[IDX_W'(i) + ptr];
      end
   end

   // Lowest set bit of the rotated vector; the downward scan leaves the lowest one in off.
   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
         end
      end
   end

   // Undo the rotation; the 4-bit add wraps naturally modulo 16.
   assign idx = ptr + off;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 16 requesters with a registered winner index and enable.
// Each grant lasts a programmable dwell, and consecutive grants are separated by a
// one-cycle dead gap so the downstream one-hot decoder lines never overlap.
module rr_index_arbiter
   import arb_pkg::*;
#(
   parameter int HOLD_W = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   input  logic [HOLD_W-1:0] hold_cycles,
   input  logic              done,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              grant_en
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  ptr_nxt;
   logic [HOLD_W-1:0] cnt;
   logic [HOLD_W-1:0] cnt_nxt;
   logic [IDX_W-1:0]  idx_nxt;
   logic              en_nxt;
   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic              release_now;

   rr_priority_pick u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // The dwell is only counted down from the value latched at grant time. A latched
   // hold of 0 leaves cnt at 0, so cnt==1 can only be reached by a nonzero dwell.
   // Several causes in one cycle still produce a single release.
   assign release_now = done | ~req[grant_idx] | (cnt == HOLD_W'(1));

   // Next-state logic: arbitrate from IDLE or GAP, hold the grant until a release cause.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      idx_nxt   = grant_idx;
      en_nxt    = grant_en;
      case (state)
         IDLE, GAP: begin
            if (pick_any) begin
               state_nxt = GRANT;
               idx_nxt   = pick_idx;
               en_nxt    = 1'b1;
               cnt_nxt   = hold_cycles;
            end else begin
               state_nxt = IDLE;
               en_nxt    = 1'b0;
            end
         end
         GRANT: begin
            en_nxt = 1'b1;
            if (release_now) begin
               state_nxt = GAP;
               en_nxt    = 1'b0;
               ptr_nxt   = grant_idx + IDX_W'(1);
               cnt_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - HOLD_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            en_nxt    = 1'b0;
         end
      endcase
   end

   // State, pointer, dwell counter and output registers; reset clears them immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         grant_idx <= '0;
         grant_en  <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         grant_idx <= idx_nxt;
         grant_en  <= en_nxt;
      end
   end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed self-checking bench for rr_index_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rr_index_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic [7:0]  hold_cycles;
   logic        done;
   logic [3:0]  grant_idx;
   logic        grant_en;

   int checks = 0;
   int fails  = 0;

   rr_index_arbiter #(.HOLD_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .hold_cycles (hold_cycles),
      .done        (done),
      .grant_idx   (grant_idx),
      .grant_en    (grant_en)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Return the arbiter to IDLE with ptr=0, ending on a falling edge with reset released.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reset held for three cycles with every requester active.
   task automatic test_reset();
      rst_n       = 1'b0;
      req         = 16'hFFFF;
      hold_cycles = 8'd3;
      done        = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (grant_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_en c%0d: got %b expected 0", c, grant_en);
         end
         checks++;
         if (grant_idx !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_idx c%0d: got %0d expected 0", c, grant_idx);
         end
      end
      req   = '0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (grant_en !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_idle_en: got %b expected 0", grant_en);
      end
   endtask

   // Dwell of 3 on requester 5, then a regrant after one gap cycle.
   // hold_cycles changes mid-grant, which must not affect the running dwell.
   task automatic test_dwell();
      logic exp_en [0:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      hold_cycles = 8'd3;
      req         = 16'h0020;
      checks++;
      if (grant_en !== 1'b0) begin
         fails++;
         $display("[TB] FAIL dwell_pre_en: got %b expected 0", grant_en);
      end
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if (grant_en !== exp_en[c-1]) begin
            fails++;
            $display("[TB] FAIL dwell_en N+%0d: got %b expected %b", c, grant_en, exp_en[c-1]);
         end
         checks++;
         if (grant_idx !== 4'd5) begin
            fails++;
            $display("[TB] FAIL dwell_idx N+%0d: got %0d expected 5", c, grant_idx);
         end
         if (c == 2) hold_cycles = 8'd1;
         if (c == 4) hold_cycles = 8'd3;
      end
      do_reset();
   endtask

   // All requesters active with dwell 1: indices 0..15 then 0, alternating with gaps.
   task automatic test_sweep();
      logic [15:0] prev_oh;
      logic [15:0] cur_oh;
      @(negedge clk);
      hold_cycles = 8'd1;
      req         = 16'hFFFF;
      prev_oh     = '0;
      for (int k = 0; k <= 16; k++) begin
         for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            checks++;
            if (grant_en !== (ph == 0)) begin
               fails++;
               $display("[TB] FAIL sweep_en k%0d ph%0d: got %b expected %b", k, ph, grant_en, (ph == 0));
            end
            checks++;
            if (grant_idx !== 4'(k % 16)) begin
               fails++;
               $display("[TB] FAIL sweep_idx k%0d ph%0d: got %0d expected %0d", k, ph, grant_idx, k % 16);
            end
            cur_oh = grant_en ? (16'd1 << grant_idx) : 16'd0;
            checks++;
            if ((prev_oh & cur_oh) !== 16'd0) begin
               fails++;
               $display("[TB] FAIL sweep_overlap k%0d ph%0d: got %h expected 0000", k, ph, prev_oh & cur_oh);
            end
            prev_oh = cur_oh;
         end
      end
      do_reset();
   endtask

   // Grant 14 moves ptr to 15; requests {0,3,15} with dwell 2 then give 15, 0, 3, 15.
   task automatic test_wrap();
      int g_list [0:3] = '{15, 0, 3, 15};
      @(negedge clk);
      hold_cycles = 8'd2;
      req         = 16'h4000;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if (grant_en !== 1'b1 || grant_idx !== 4'd14) begin
            fails++;
            $display("[TB] FAIL wrap_first c%0d: got en=%b idx=%0d expected en=1 idx=14", c, grant_en, grant_idx);
         end
      end
      req = 16'h8009;
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         checks++;
         if (grant_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_gap g%0d: got %b expected 0", g, grant_en);
         end
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (grant_en !== 1'b1 || grant_idx !== 4'(g_list[g])) begin
               fails++;
               $display("[TB] FAIL wrap_grant g%0d c%0d: got en=%b idx=%0d expected en=1 idx=%0d",
                        g, c, grant_en, grant_idx, g_list[g]);
            end
         end
      end
      do_reset();
   endtask

   // Unlimited dwell on requester 9, released first by done, then by dropping req[9].
   task automatic test_release();
      @(negedge clk);
      hold_cycles = 8'd0;
      req         = 16'h0200;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checks++;
         if (grant_en !== 1'b1 || grant_idx !== 4'd9) begin
            fails++;
            $display("[TB] FAIL rel_done_grant c%0d: got en=%b idx=%0d expected en=1 idx=9", c, grant_en, grant_idx);
         end
      end
      done = 1'b1;
      @(negedge clk);
      checks++;
      if (grant_en !== 1'b0 || grant_idx !== 4'd9) begin
         fails++;
         $display("[TB] FAIL rel_done_gap: got en=%b idx=%0d expected en=0 idx=9", grant_en, grant_idx);
      end
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         done = 1'b0;
         checks++;
         if (grant_en !== 1'b1 || grant_idx !== 4'd9) begin
            fails++;
            $display("[TB] FAIL rel_req_grant c%0d: got en=%b idx=%0d expected en=1 idx=9", c, grant_en, grant_idx);
         end
      end
      req = 16'h0000;
      @(negedge clk);
      done = 1'b1;
      checks++;
      if (grant_en !== 1'b0 || grant_idx !== 4'd9) begin
         fails++;
         $display("[TB] FAIL rel_req_gap: got en=%b idx=%0d expected en=0 idx=9", grant_en, grant_idx);
      end
      @(negedge clk);
      done = 1'b0;
      checks++;
      if (grant_en !== 1'b0 || grant_idx !== 4'd9) begin
         fails++;
         $display("[TB] FAIL rel_idle_hold: got en=%b idx=%0d expected en=0 idx=9", grant_en, grant_idx);
      end
      req = 16'h0200;
      @(negedge clk);
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 4'd9) begin
         fails++;
         $display("[TB] FAIL rel_regrant: got en=%b idx=%0d expected en=1 idx=9", grant_en, grant_idx);
      end
      do_reset();
   endtask

   // Asynchronous reset in the middle of a grant to 11; afterwards the scan restarts at 0.
   task automatic test_async_reset();
      @(negedge clk);
      hold_cycles = 8'd0;
      req         = 16'h0010;
      @(negedge clk);
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 4'd4) begin
         fails++;
         $display("[TB] FAIL arst_first: got en=%b idx=%0d expected en=1 idx=4", grant_en, grant_idx);
      end
      req = 16'h0800;
      @(negedge clk);
      req = 16'h0810;
      checks++;
      if (grant_en !== 1'b0) begin
         fails++;
         $display("[TB] FAIL arst_gap: got %b expected 0", grant_en);
      end
      @(negedge clk);
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 4'd11) begin
         fails++;
         $display("[TB] FAIL arst_second: got en=%b idx=%0d expected en=1 idx=11", grant_en, grant_idx);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant_en !== 1'b0 || grant_idx !== 4'd0) begin
         fails++;
         $display("[TB] FAIL arst_immediate: got en=%b idx=%0d expected en=0 idx=0", grant_en, grant_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (grant_en !== 1'b1 || grant_idx !== 4'd4) begin
         fails++;
         $display("[TB] FAIL arst_after: got en=%b idx=%0d expected en=1 idx=4", grant_en, grant_idx);
      end
      do_reset();
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_dwell();
      test_sweep();
      test_wrap();
      test_release();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
